spi_flash_rd_ctrl: RTL and testbench

Single-SPI read master that sequences the board's serial flash for CPU instruction and data fetches. After reset it wakes the flash with a 0xAB release-from-power-down command. It then serves 32-bit word reads from a valid/ready memory port using the 0x03 READ command. Consecutive sequential words are streamed without re-issuing the command; the chip select is held low between them.

---
 rtl/spi_flash_pkg.sv | 44 ++++
 rtl/spi_flash_shift.sv | 91 +++++++++
 rtl/spi_flash_rd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_flash_rd_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// ============================================================================
//  Module   : spi_flash_pkg
//  Brief    : Opcodes, FSM state encoding and helpers for the SPI flash reader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [7:0] CMD_SLEEP = 8'hB9;

  typedef enum logic [3:0] {
    ST_WAKE_CMD  = 4'd0,
    ST_WAKE_WAIT = 4'd1,
    ST_IDLE      = 4'd2,
    ST_GAP       = 4'd3,
    ST_CMD       = 4'd4,
    ST_ADDR      = 4'd5,
    ST_DATA      = 4'd6,
    ST_RESP      = 4'd7,
    ST_STREAM    = 4'd8
  } state_t;

  // States in which the chip select is held low.
  function automatic logic csb_active(input state_t s);
    return (s == ST_WAKE_CMD) || (s == ST_CMD) || (s == ST_ADDR) ||
           (s == ST_DATA) || (s == ST_RESP) || (s == ST_STREAM);
  endfunction

  // States in which the master drives MOSI.
  function automatic logic mosi_active(input state_t s);
    return (s == ST_WAKE_CMD) || (s == ST_CMD) || (s == ST_ADDR);
  endfunction

  // Flash returns the lowest-addressed byte first; the CPU wants it in [7:0].
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_shift.sv
// ============================================================================
//  Module   : spi_flash_shift
//  Brief    : SPI mode-0 clock divider with 32-bit MSB-first shift in/out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_shift #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic [5:0]  i_nbits,
  input  logic [31:0] i_tx,
  input  logic        i_io1,
  output logic        o_done,
  output logic [31:0] o_rx,
  output logic        o_sclk,
  output logic        o_mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic             r_busy;
  logic             r_sclk;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_bits;
  logic [31:0]      r_sr;
  logic [31:0]      r_rx;
  logic             r_do;

  logic             w_tick;
  logic             w_done;
  logic [5:0]       w_shamt;
  logic [31:0]      w_aligned;

  always_comb begin
    w_tick    = r_busy && (r_div == C_DIV_MAX);
    w_done    = w_tick && r_sclk && (r_bits == 6'd1);
    w_shamt   = 6'd32 - i_nbits;
    w_aligned = i_tx << w_shamt;
  end

  // A start on the done cycle chains the next field with no idle bit time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_bits <= '0;
      r_sr   <= '0;
      r_rx   <= '0;
      r_do   <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_bits <= i_nbits;
      r_do   <= w_aligned[31];
      r_sr   <= {w_aligned[30:0], 1'b0};
    end else if (w_tick) begin
      r_div <= '0;
      if (!r_sclk) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[30:0], i_io1};
      end else begin
        r_sclk <= 1'b0;
        r_bits <= r_bits - 6'd1;
        if (r_bits == 6'd1) begin
          r_busy <= 1'b0;
          r_do   <= 1'b0;
        end else begin
          r_do <= r_sr[31];
          r_sr <= {r_sr[30:0], 1'b0};
        end
      end
    end else if (r_busy) begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_done = w_done;
  assign o_rx   = r_rx;
  assign o_sclk = r_sclk;
  assign o_mosi = r_do;

endmodule

`default_nettype wire

// File: rtl/spi_flash_rd_ctrl.sv
// ============================================================================
//  Module   : spi_flash_rd_ctrl
//  Brief    : Single-SPI flash read master with wake-up and sequential streaming.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_rd_ctrl
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV     = 1,
  parameter int CSH_CYCLES  = 4,
  parameter int WAKE_CYCLES = 16,
  parameter int IDLE_TO     = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [23:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        init_done,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_oe,
  output logic        flash_io0_do,
  input  logic        flash_io1_di
);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [21:0] r_addr;
  logic        r_kick;
  logic        r_csb;
  logic        r_oe;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_init;

  state_t      w_next;
  logic        w_start;
  logic [5:0]  w_nbits;
  logic [31:0] w_tx;
  logic        w_done;
  logic [31:0] w_rx;
  logic        w_match;
  logic        w_unused_addr;

  assign w_unused_addr = ^mem_addr[1:0];
  assign w_match       = (mem_addr[23:2] == r_addr + 22'd1);

  spi_flash_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .resetn  (resetn),
    .i_start (w_start),
    .i_nbits (w_nbits),
    .i_tx    (w_tx),
    .i_io1   (flash_io1_di),
    .o_done  (w_done),
    .o_rx    (w_rx),
    .o_sclk  (flash_clk),
    .o_mosi  (flash_io0_do)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_nbits = 6'd8;
    w_tx    = 32'd0;
    case (r_state)
      ST_WAKE_CMD: begin
        if (r_kick) begin
          w_start = 1'b1;
          w_tx    = {24'd0, CMD_WAKE};
        end else if (w_done) begin
          w_next = ST_WAKE_WAIT;
        end
      end
      ST_WAKE_WAIT: begin
        if (r_cnt == 16'(WAKE_CYCLES - 1)) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (mem_valid) w_next = ST_CMD;
      end
      ST_GAP: begin
        if (r_cnt == 16'(CSH_CYCLES - 1)) w_next = mem_valid ? ST_CMD : ST_IDLE;
      end
      ST_CMD: begin
        if (r_kick) begin
          w_start = 1'b1;
          w_tx    = {24'd0, CMD_READ};
        end else if (w_done) begin
          w_start = 1'b1;
          w_nbits = 6'd24;
          w_tx    = {8'd0, r_addr, 2'b00};
          w_next  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_done) begin
          w_start = 1'b1;
          w_nbits = 6'd32;
          w_next  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_done) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (mem_valid) begin
          if (w_match) begin
            w_start = 1'b1;
            w_nbits = 6'd32;
            w_next  = ST_DATA;
          end else begin
            w_next = ST_GAP;
          end
        end else if (r_cnt == 16'(IDLE_TO - 1)) begin
          w_next = ST_GAP;
        end
      end
      default: w_next = ST_WAKE_CMD;
    endcase
  end

  // r_kick is set at reset so the wake command launches on the first cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_WAKE_CMD;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_kick  <= 1'b1;
      r_csb   <= 1'b1;
      r_oe    <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      r_kick  <= (w_next == ST_CMD) && (r_state != ST_CMD);
      r_csb   <= !csb_active(w_next);
      r_oe    <= mosi_active(w_next);
      r_ready <= (w_next == ST_RESP);
      if (w_next == ST_RESP) r_rdata <= bswap32(w_rx);
      if ((r_state == ST_WAKE_WAIT) && (w_next == ST_IDLE)) r_init <= 1'b1;
      if ((w_next == ST_CMD) && (r_state != ST_CMD)) begin
        r_addr <= mem_addr[23:2];
      end else if ((r_state == ST_STREAM) && (w_next == ST_DATA)) begin
        r_addr <= r_addr + 22'd1;
      end
    end
  end

  assign mem_ready    = r_ready;
  assign mem_rdata    = r_rdata;
  assign init_done    = r_init;
  assign flash_csb    = r_csb;
  assign flash_io0_oe = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_rd_ctrl.sv
// ============================================================================
//  Module   : tb_spi_flash_rd_ctrl
//  Brief    : Directed bench with a behavioural SPI flash for two CLK_DIV builds.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_rd_ctrl;

  logic        clk;
  logic        resetn;
  logic        valid1, valid3;
  logic [23:0] mem_addr;
  logic        miso;
  logic        sel;

  logic        ready1, ready3, init1, init3;
  logic [31:0] rdata1, rdata3;
  logic        csb1, csb3, fclk1, fclk3, oe1, oe3, do1, do3;

  wire         w_ready = sel ? ready3 : ready1;
  wire  [31:0] w_rdata = sel ? rdata3 : rdata1;
  wire         w_init  = sel ? init3  : init1;
  wire         w_csb   = sel ? csb3   : csb1;
  wire         w_fclk  = sel ? fclk3  : fclk1;
  wire         w_oe    = sel ? oe3    : oe1;
  wire         w_do    = sel ? do3    : do1;

  int n_cmp, n_fail;

  spi_flash_rd_ctrl #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .mem_valid(valid1), .mem_addr(mem_addr),
    .mem_ready(ready1), .mem_rdata(rdata1), .init_done(init1),
    .flash_csb(csb1), .flash_clk(fclk1), .flash_io0_oe(oe1),
    .flash_io0_do(do1), .flash_io1_di(miso)
  );

  spi_flash_rd_ctrl #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .mem_valid(valid3), .mem_addr(mem_addr),
    .mem_ready(ready3), .mem_rdata(rdata3), .init_done(init3),
    .flash_csb(csb3), .flash_clk(fclk3), .flash_io0_oe(oe3),
    .flash_io0_do(do3), .flash_io1_di(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash content: byte at 0x10xxxx equals its low address byte.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] + a[23:16] - 8'h10;
  endfunction

  int          m_bits, m_pulses, m_last_pulses, n_read_cmds;
  logic [7:0]  m_op;
  logic [23:0] m_addr, m_cmd_addr;
  bit          m_powered;
  int          hi_run, last_hi;

  initial begin
    m_bits = 0; m_pulses = 0; m_last_pulses = 0; n_read_cmds = 0;
    m_op = 8'h00; m_addr = '0; m_cmd_addr = '0; m_powered = 1'b0;
    hi_run = 0; last_hi = 0; miso = 1'b0;
  end

  always @(negedge w_csb) begin
    m_bits = 0; m_pulses = 0; m_op = 8'h00;
  end

  always @(posedge w_csb) m_last_pulses = m_pulses;

  always @(posedge w_fclk) begin
    if (!w_csb) begin
      m_pulses++;
      if (m_bits < 8) m_op = {m_op[6:0], (w_oe ? w_do : 1'bx)};
      else if (m_op == 8'h03 && m_bits < 32) m_addr = {m_addr[22:0], w_do};
      m_bits++;
      if (m_bits == 8 && m_op == 8'hAB) m_powered = 1'b1;
      if (m_bits == 8 && m_op == 8'h03) n_read_cmds++;
      if (m_bits == 32 && m_op == 8'h03) m_cmd_addr = m_addr;
    end
  end

  always @(negedge w_fclk) begin
    if (!w_csb && m_op == 8'h03 && m_bits >= 32) begin
      automatic int          j  = m_bits - 32;
      automatic logic [23:0] ba = m_addr + 24'(j / 8);
      automatic logic [7:0]  b  = flash_byte(ba);
      miso = b[7 - (j % 8)];
    end
  end

  always @(negedge clk) begin
    if (w_csb) hi_run++;
    else if (hi_run != 0) begin
      last_hi = hi_run;
      hi_run  = 0;
    end
  end

  task automatic set_valid(input logic v);
    if (sel) valid3 = v;
    else     valid1 = v;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_read(input logic [23:0] a, input bit hold,
                         output logic [31:0] d, output int lat);
    mem_addr = a;
    set_valid(1'b1);
    lat = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (w_ready) break;
      lat++;
    end
    if (!w_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL read_timeout addr=%06h: mem_ready never seen, required within 3000 cycles", a);
      lat = -1;
    end
    d = w_rdata;
    if (!hold) set_valid(1'b0);
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (w_init) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int wake_hi;
    bit csb_ok;
    @(negedge clk);
    n_cmp++;
    if ({w_csb, w_fclk, w_oe, w_do, w_ready, w_init} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {csb,clk,oe,do,ready,init}=%b, required 100000",
               {w_csb, w_fclk, w_oe, w_do, w_ready, w_init});
    end
    n_cmp++;
    if (w_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %08h, required 00000000", w_rdata);
    end
    resetn = 1'b1;
    for (int i = 0; i < 100 && w_csb; i++) @(negedge clk);
    for (int i = 0; i < 200 && !w_csb; i++) @(negedge clk);
    wake_hi = 0; csb_ok = 1'b1;
    for (int i = 0; i < 200 && !w_init; i++) begin
      if (w_csb) wake_hi++; else csb_ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (m_last_pulses !== 8) begin
      n_fail++; $display("FAIL wake_pulses: got %0d, required 8", m_last_pulses);
    end
    n_cmp++;
    if (m_op !== 8'hAB || m_powered !== 1'b1) begin
      n_fail++; $display("FAIL wake_opcode: got %02h powered=%0d, required AB powered=1", m_op, m_powered);
    end
    n_cmp++;
    if (wake_hi !== 16 || csb_ok !== 1'b1 || w_init !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_wait: csb-high cycles=%0d csb_ok=%0d init=%0d, required 16/1/1",
               wake_hi, csb_ok, w_init);
    end
  endtask

  task automatic test_single;
    logic [31:0] d; int lat; int cmds0;
    cmds0 = n_read_cmds;
    do_read(24'h100000, 1'b0, d, lat);
    n_cmp++;
    if (d !== 32'h03020100) begin
      n_fail++; $display("FAIL single_data: got %08h, required 03020100", d);
    end
    n_cmp++;
    if (lat !== 130) begin
      n_fail++; $display("FAIL single_latency: got %0d, required 130", lat);
    end
    n_cmp++;
    if (m_pulses !== 64 || n_read_cmds - cmds0 !== 1 || m_cmd_addr !== 24'h100000) begin
      n_fail++;
      $display("FAIL single_bus: pulses=%0d cmds=%0d addr=%06h, required 64/1/100000",
               m_pulses, n_read_cmds - cmds0, m_cmd_addr);
    end
    idle_cycles(60);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d0, d1, d2; int l0, l1, l2; int cmds0;
    cmds0 = n_read_cmds;
    do_read(24'h100000, 1'b1, d0, l0);
    do_read(24'h100004, 1'b1, d1, l1);
    do_read(24'h100008, 1'b0, d2, l2);
    n_cmp++;
    if ({d0, d1, d2} !== {32'h03020100, 32'h07060504, 32'h0B0A0908}) begin
      n_fail++;
      $display("FAIL b2b_data: got %08h %08h %08h, required 03020100 07060504 0B0A0908", d0, d1, d2);
    end
    n_cmp++;
    if (l1 !== 66 || l2 !== 66) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d %0d, required 66 66", l1, l2);
    end
    n_cmp++;
    if (n_read_cmds - cmds0 !== 1) begin
      n_fail++; $display("FAIL b2b_cmds: got %0d read commands, required 1", n_read_cmds - cmds0);
    end
    idle_cycles(60);
  endtask

  task automatic test_nonseq;
    logic [31:0] d0, d1; int l0, l1; int cmds0;
    cmds0 = n_read_cmds;
    do_read(24'h100000, 1'b1, d0, l0);
    do_read(24'h100010, 1'b0, d1, l1);
    n_cmp++;
    if (d1 !== 32'h13121110 || m_cmd_addr !== 24'h100010) begin
      n_fail++; $display("FAIL nonseq_data: got %08h addr=%06h, required 13121110 100010", d1, m_cmd_addr);
    end
    n_cmp++;
    if (l1 !== 135 || n_read_cmds - cmds0 !== 2) begin
      n_fail++; $display("FAIL nonseq_latency: got %0d cmds=%0d, required 135 cmds=2", l1, n_read_cmds - cmds0);
    end
    n_cmp++;
    if ((last_hi >= 4) !== 1'b1) begin
      n_fail++; $display("FAIL nonseq_csh: csb high %0d cycles, required at least 4", last_hi);
    end
    idle_cycles(60);
  endtask

  task automatic test_timeout;
    logic [31:0] d; int lat; int cmds0; logic csb_mid, csb_late;
    do_read(24'h100000, 1'b0, d, lat);
    idle_cycles(20);
    csb_mid = w_csb;
    idle_cycles(20);
    csb_late = w_csb;
    n_cmp++;
    if ({csb_mid, csb_late} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_csb: csb at +20=%0d +40=%0d, required 0 then 1", csb_mid, csb_late);
    end
    cmds0 = n_read_cmds;
    do_read(24'h100004, 1'b0, d, lat);
    n_cmp++;
    if (d !== 32'h07060504 || lat !== 130 || n_read_cmds - cmds0 !== 1) begin
      n_fail++;
      $display("FAIL timeout_reread: data=%08h lat=%0d cmds=%0d, required 07060504/130/1",
               d, lat, n_read_cmds - cmds0);
    end
    idle_cycles(60);
  endtask

  task automatic test_wrap;
    logic [31:0] d0, d1; int l0, l1; int cmds0;
    cmds0 = n_read_cmds;
    do_read(24'hFFFFFC, 1'b1, d0, l0);
    do_read(24'h000000, 1'b0, d1, l1);
    n_cmp++;
    if (d0 !== 32'hEEEDECEB || d1 !== 32'hF3F2F1F0) begin
      n_fail++; $display("FAIL wrap_data: got %08h %08h, required EEEDECEB F3F2F1F0", d0, d1);
    end
    n_cmp++;
    if (l1 !== 66 || n_read_cmds - cmds0 !== 1) begin
      n_fail++; $display("FAIL wrap_stream: lat=%0d cmds=%0d, required 66/1", l1, n_read_cmds - cmds0);
    end
    idle_cycles(60);
  endtask

  task automatic test_reset_mid(input int into_data, input int lat_exp);
    logic [31:0] d; int lat; bit ok;
    mem_addr = 24'h100000;
    set_valid(1'b1);
    idle_cycles(into_data);
    set_valid(1'b0);
    resetn = 1'b0;
    m_powered = 1'b0;
    #1;
    n_cmp++;
    if ({w_csb, w_ready, w_fclk, w_oe, w_init} !== 5'b10000) begin
      n_fail++;
      $display("FAIL midreset_outputs: {csb,ready,clk,oe,init}=%b, required 10000",
               {w_csb, w_ready, w_fclk, w_oe, w_init});
    end
    idle_cycles(3);
    resetn = 1'b1;
    do_read(24'h100000, 1'b0, d, lat);
    n_cmp++;
    if (d !== 32'h03020100 || m_powered !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pending: data=%08h powered=%0d, required 03020100/1", d, m_powered);
    end
    idle_cycles(300);
    wait_init(ok);
    do_read(24'h100004, 1'b0, d, lat);
    n_cmp++;
    if (d !== 32'h07060504 || lat !== lat_exp || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reread: data=%08h lat=%0d init=%0d, required 07060504/%0d/1",
               d, lat, ok, lat_exp);
    end
    idle_cycles(300);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    sel = 1'b0; resetn = 1'b0; valid1 = 1'b0; valid3 = 1'b0; mem_addr = '0;
    idle_cycles(3);
    test_reset;
    test_single;
    test_back_to_back;
    test_nonseq;
    test_timeout;
    test_wrap;
    test_reset_mid(90, 130);
    sel = 1'b1;
    idle_cycles(2);
    test_reset_mid(250, 386);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
